// File: rtl/hazard_fwd_ctl_pkg.sv
// Shared definitions for the RF-stage hazard/forwarding controller:
// fwd_mux select codes and the in-flight scoreboard entry layout.
package mips789_defs;

  localparam int REG_AW = 5;

  // Codes 3..7 are reserved; fwd_mux decodes them as FW_NONE.
  localparam logic [2:0] FW_NONE = 3'd0;
  localparam logic [2:0] FW_ALU  = 3'd1;
  localparam logic [2:0] FW_MEM  = 3'd2;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] addr;
    logic              ld;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding select: picks the youngest in-flight producer of
// idx and flags when that producer is a load still sitting in EX.
import mips789_defs::*;

module fwd_sel #(
  parameter bit REG_ZERO_FWD = 1'b0
) (
  input  logic [4:0] idx,
  input  logic       use_op,
  input  sb_entry_t  ex,
  input  sb_entry_t  mem,
  output logic [2:0] code,
  output logic       ld_hit
);

  logic idx_ok;
  logic ex_hit;
  logic mem_hit;
  logic mem_ld_unused;

  assign idx_ok  = (idx != 5'd0) | REG_ZERO_FWD;
  assign ex_hit  = use_op & ex.v  & (ex.addr  == idx) & idx_ok;
  assign mem_hit = use_op & mem.v & (mem.addr == idx) & idx_ok;
  assign ld_hit  = ex_hit & ex.ld;

  // A load in MEM has its data by now, so its ld flag does not matter here.
  assign mem_ld_unused = mem.ld;

  always_comb begin
    code = FW_NONE;
    if (ex_hit && !ex.ld) begin
      code = FW_ALU;
    end else if (mem_hit) begin
      code = FW_MEM;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctl.sv
// RF-stage hazard and forwarding controller: EX/MEM/WB destination
// scoreboard, rs/rt forwarding selects, load-use stall and stall counter.
import mips789_defs::*;

module hazard_fwd_ctl #(
  parameter int STALL_CNT_W  = 16,
  parameter bit REG_ZERO_FWD = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_i,
  input  logic                   pause,
  input  logic [4:0]             rs_n_i,
  input  logic [4:0]             rt_n_i,
  input  logic                   rs_use_i,
  input  logic                   rt_use_i,
  input  logic [4:0]             rd_index_i,
  input  logic                   rd_we_i,
  input  logic                   is_load_i,
  input  logic                   ra2ex_clr_i,
  output logic [2:0]             fw_cmp_rs,
  output logic [2:0]             fw_cmp_rt,
  output logic                   stall_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  sb_entry_t ex_q;
  sb_entry_t mem_q;
  sb_entry_t wb_q;
  sb_entry_t ex_d;

  logic [2:0] rs_code;
  logic [2:0] rt_code;
  logic       rs_ld_hit;
  logic       rt_ld_hit;
  logic       wb_unused;

  fwd_sel #(.REG_ZERO_FWD(REG_ZERO_FWD)) u_fwd_rs (
    .idx    (rs_n_i),
    .use_op (rs_use_i),
    .ex     (ex_q),
    .mem    (mem_q),
    .code   (rs_code),
    .ld_hit (rs_ld_hit)
  );

  fwd_sel #(.REG_ZERO_FWD(REG_ZERO_FWD)) u_fwd_rt (
    .idx    (rt_n_i),
    .use_op (rt_use_i),
    .ex     (ex_q),
    .mem    (mem_q),
    .code   (rt_code),
    .ld_hit (rt_ld_hit)
  );

  assign stall_o = !pause & (rs_ld_hit | rt_ld_hit);

  // The operand waiting on the load gets FW_NONE; it is re-evaluated after the bubble.
  assign fw_cmp_rs = (stall_o & rs_ld_hit) ? FW_NONE : rs_code;
  assign fw_cmp_rt = (stall_o & rt_ld_hit) ? FW_NONE : rt_code;

  // WB is tracked for completeness; the register file write-through covers it.
  assign wb_unused = ^wb_q;

  always_comb begin
    ex_d = SB_EMPTY;
    if (!(ra2ex_clr_i | stall_o)) begin
      ex_d.v    = rd_we_i & ((rd_index_i != 5'd0) | REG_ZERO_FWD);
      ex_d.addr = rd_index_i;
      ex_d.ld   = is_load_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      ex_q        <= SB_EMPTY;
      mem_q       <= SB_EMPTY;
      wb_q        <= SB_EMPTY;
      stall_cnt_o <= '0;
    end else if (!pause) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_d;
      if (stall_o && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + 1'b1;
      end
    end
  end

endmodule
